// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32 multi-cycle control unit.
// Imported by the ALU decoder and the main control FSM.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWRITE = 4'd4,
    MEMWB    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and instruction fields onto the ALU
// operation select.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output alu_ctrl_t   alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) may subtract; addi with imm[10]=1 still adds.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the RV32 multi-cycle core: Moore sequencing FSM,
// branch resolution and ALU decode, driving all datapath enables and selects.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal
);

  state_t    state, state_next;
  alu_op_t   alu_op;
  alu_ctrl_t alu_control;
  logic      pc_update, branch, mem_write, ir_write, reg_write;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BR:        state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      JAL:      state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    case (state)
      FETCH: begin
        ir_write  = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Enables are gated by reset so nothing writes while the core is held.
  // funct3[0] flips the sense of Zero: beq takes on Zero, bne on !Zero.
  assign PCWrite    = reset & (pc_update | (branch & (Zero ^ funct3[0])));
  assign IRWrite    = reset & ir_write;
  assign MemWrite   = reset & mem_write;
  assign RegWrite   = reset & reg_write;
  assign ImmSrc     = imm_src_for(op);
  assign ALUControl = alu_control;
  assign illegal    = (state == TRAP);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle output vectors for each
// instruction class, plus reset/abort/trap sequences.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       rw;
    logic       ill;
  } out_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       n_PCWrite, n_AdrSrc, n_MemWrite, n_IRWrite, n_RegWrite, n_illegal;
  logic [1:0] n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ImmSrc;
  logic [2:0] n_ALUControl;

  out_t act, act_nop;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .illegal(illegal)
  );

  multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(n_PCWrite), .AdrSrc(n_AdrSrc), .MemWrite(n_MemWrite),
    .IRWrite(n_IRWrite), .ResultSrc(n_ResultSrc), .ALUSrcA(n_ALUSrcA),
    .ALUSrcB(n_ALUSrcB), .ImmSrc(n_ImmSrc), .ALUControl(n_ALUControl),
    .RegWrite(n_RegWrite), .illegal(n_illegal)
  );

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal};
  assign act_nop = {n_PCWrite, n_AdrSrc, n_MemWrite, n_IRWrite, n_ResultSrc,
                    n_ALUSrcA, n_ALUSrcB, n_ImmSrc, n_ALUControl, n_RegWrite,
                    n_illegal};

  function automatic out_t o(input logic pcw, input logic adr, input logic mw,
                             input logic irw, input logic [1:0] rs,
                             input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] imm, input logic [2:0] alu,
                             input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
  endfunction

  // Hand-written per-state vectors.
  function automatic out_t f_fetch(input logic [1:0] imm);
    return o(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
  endfunction
  function automatic out_t f_decode(input logic [1:0] imm);
    return o(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
  endfunction
  function automatic out_t f_reset(input logic [1:0] imm);
    return o(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
  endfunction
  function automatic out_t f_exec(input logic [1:0] sb, input logic [2:0] alu);
    return o(0, 0, 0, 0, 2'b00, 2'b10, sb, 2'b00, alu, 0, 0);
  endfunction
  function automatic out_t f_wb(input logic [1:0] imm, input logic [1:0] rs);
    return o(0, 0, 0, 0, rs, 2'b00, 2'b00, imm, 3'b000, 1, 0);
  endfunction
  function automatic out_t f_beq(input logic pcw);
    return o(pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0);
  endfunction

  task automatic add(input string name, input logic [6:0] v_op, input logic [2:0] f3,
                     input logic f7, input logic z, input out_t e);
    vec_t v;
    v.name = name; v.op = v_op; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h (pcw%b adr%b mw%b irw%b rs%b sa%b sb%b imm%b alu%b rw%b ill%b) expected %05h",
               name, got, got.pcw, got.adr, got.mw, got.irw, got.rs, got.sa,
               got.sb, got.imm, got.alu, got.rw, got.ill, exp);
    end
  endtask

  task automatic step(input vec_t v);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z;
    #1 check(v.name, act, v.exp);
    @(negedge clk);
  endtask

  // Adds the FETCH/DECODE pair shared by every instruction.
  task automatic add_fd(input string name, input logic [6:0] v_op, input logic [2:0] f3,
                        input logic f7, input logic [1:0] imm);
    add({name, "_fetch"}, v_op, f3, f7, 0, f_fetch(imm));
    add({name, "_decode"}, v_op, f3, f7, 0, f_decode(imm));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // lw: 5 cycles, RegWrite only in MEMWB with ResultSrc=01
    add_fd("lw", 7'b0000011, 3'b010, 0, 2'b00);
    add("lw_memadr", 7'b0000011, 3'b010, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    add("lw_memread", 7'b0000011, 3'b010, 0, 1, o(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    add("lw_memwb", 7'b0000011, 3'b010, 0, 0, f_wb(2'b00, 2'b01));
    // R-type variants
    add_fd("sub", 7'b0110011, 3'b000, 1, 2'b00);
    add("sub_exec", 7'b0110011, 3'b000, 1, 0, f_exec(2'b00, 3'b001));
    add("sub_aluwb", 7'b0110011, 3'b000, 1, 0, f_wb(2'b00, 2'b00));
    add_fd("add", 7'b0110011, 3'b000, 0, 2'b00);
    add("add_exec", 7'b0110011, 3'b000, 0, 0, f_exec(2'b00, 3'b000));
    add("add_aluwb", 7'b0110011, 3'b000, 0, 0, f_wb(2'b00, 2'b00));
    add_fd("or", 7'b0110011, 3'b110, 0, 2'b00);
    add("or_exec", 7'b0110011, 3'b110, 0, 0, f_exec(2'b00, 3'b011));
    add("or_aluwb", 7'b0110011, 3'b110, 0, 0, f_wb(2'b00, 2'b00));
    add_fd("and", 7'b0110011, 3'b111, 0, 2'b00);
    add("and_exec", 7'b0110011, 3'b111, 0, 0, f_exec(2'b00, 3'b010));
    add("and_aluwb", 7'b0110011, 3'b111, 0, 0, f_wb(2'b00, 2'b00));
    add_fd("slt", 7'b0110011, 3'b010, 0, 2'b00);
    add("slt_exec", 7'b0110011, 3'b010, 0, 0, f_exec(2'b00, 3'b101));
    add("slt_aluwb", 7'b0110011, 3'b010, 0, 0, f_wb(2'b00, 2'b00));
    add_fd("xor", 7'b0110011, 3'b100, 0, 2'b00);
    add("xor_exec", 7'b0110011, 3'b100, 0, 0, f_exec(2'b00, 3'b000));
    add("xor_aluwb", 7'b0110011, 3'b100, 0, 0, f_wb(2'b00, 2'b00));
    // I-type: funct7b5 set but op[5]=0, so still add
    add_fd("addi", 7'b0010011, 3'b000, 1, 2'b00);
    add("addi_exec", 7'b0010011, 3'b000, 1, 0, f_exec(2'b01, 3'b000));
    add("addi_aluwb", 7'b0010011, 3'b000, 1, 0, f_wb(2'b00, 2'b00));
    add_fd("ori", 7'b0010011, 3'b110, 0, 2'b00);
    add("ori_exec", 7'b0010011, 3'b110, 0, 0, f_exec(2'b01, 3'b011));
    add("ori_aluwb", 7'b0010011, 3'b110, 0, 0, f_wb(2'b00, 2'b00));
    // Branches: taken = Zero ^ funct3[0]; 3 cycles, back to FETCH
    add_fd("bne_z0", 7'b1100011, 3'b001, 0, 2'b10);
    add("bne_z0_beq", 7'b1100011, 3'b001, 0, 0, f_beq(1));
    add_fd("bne_z1", 7'b1100011, 3'b001, 0, 2'b10);
    add("bne_z1_beq", 7'b1100011, 3'b001, 0, 1, f_beq(0));
    add_fd("beq_z1", 7'b1100011, 3'b000, 0, 2'b10);
    add("beq_z1_beq", 7'b1100011, 3'b000, 0, 1, f_beq(1));
    add_fd("beq_z0", 7'b1100011, 3'b000, 0, 2'b10);
    add("beq_z0_beq", 7'b1100011, 3'b000, 0, 0, f_beq(0));
    // sw: MemWrite only in cycle 4
    add_fd("sw", 7'b0100011, 3'b010, 0, 2'b01);
    add("sw_memadr", 7'b0100011, 3'b010, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
    add("sw_memwrite", 7'b0100011, 3'b010, 0, 0, o(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
    // jal
    add_fd("jal", 7'b1101111, 3'b000, 0, 2'b11);
    add("jal_jal", 7'b1101111, 3'b000, 0, 1, o(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0));
    add("jal_aluwb", 7'b1101111, 3'b000, 0, 0, f_wb(2'b11, 2'b00));
    // Unsupported opcode enters TRAP and stays there
    add_fd("ecall", 7'b1110011, 3'b000, 0, 2'b00);
    add("ecall_trap1", 7'b1110011, 3'b000, 0, 0, o(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));
    add("ecall_trap2", 7'b1110011, 3'b000, 0, 1, o(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));
    add("ecall_trap3", 7'b0000011, 3'b000, 0, 0, o(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));

    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("in_reset", act, f_reset(2'b00));
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset asserted mid-TRAP clears illegal and returns to FETCH values
    op = 7'b1110011;
    reset = 1'b0;
    #1 check("trap_reset", act, f_reset(2'b00));
    @(negedge clk);
    reset = 1'b1;

    // Same illegal opcode: trapping DUT traps, NOP-configured DUT refetches
    begin
      vec_t v;
      v.op = 7'b1110011; v.f3 = 3'b000; v.f7 = 1'b0; v.z = 1'b0;
      v.name = "retrap_fetch";  v.exp = f_fetch(2'b00);  step(v);
      v.name = "retrap_decode"; v.exp = f_decode(2'b00); step(v);
      #1;
      check("retrap_trap", act, o(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));
      check("nop_refetch", act_nop, f_fetch(2'b00));
      @(negedge clk);
      reset = 1'b0;
      #1 check("retrap_reset", act, f_reset(2'b00));
      @(negedge clk);
      reset = 1'b1;

      // lw aborted by reset in MEMREAD, then an R-type restarts cleanly
      v.op = 7'b0000011; v.f3 = 3'b010;
      v.name = "abort_fetch";  v.exp = f_fetch(2'b00);  step(v);
      v.name = "abort_decode"; v.exp = f_decode(2'b00); step(v);
      v.name = "abort_memadr";
      v.exp = o(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0);
      step(v);
      reset = 1'b0;
      #1 check("abort_reset", act, f_reset(2'b00));
      @(negedge clk);
      reset = 1'b1;
      v.op = 7'b0110011; v.f3 = 3'b000; v.f7 = 1'b1;
      v.name = "restart_fetch";  v.exp = f_fetch(2'b00);           step(v);
      v.name = "restart_decode"; v.exp = f_decode(2'b00);          step(v);
      v.name = "restart_exec";   v.exp = f_exec(2'b00, 3'b001);    step(v);
      v.name = "restart_aluwb";  v.exp = f_wb(2'b00, 2'b00);       step(v);
      v.name = "restart_next";   v.exp = f_fetch(2'b00);           step(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
